// File: rtl/crc32_check.sv
// ---------------------------------------------------------------------------
// crc32_check
// Receive-side CRC-32 checker. Takes a data word plus its attached CRC-32,
// divides the (WIDTH+32)-bit codeword bit-serially (MSB first) by a
// programmable polynomial and reports whether the remainder is zero.
// Init value 0, no reflection, no final XOR.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous reset, active high
//   start      in   1       request a check; sampled only in IDLE
//   data       in   WIDTH   received data word, MSB first
//   crc_i      in   32      received CRC, follows data
//   polynom_i  in   33      generator polynomial; bit 32 implicit, ignored
//   busy       out  1       high from start accept until result
//   done       out  1       one-cycle result-valid pulse
//   ok         out  1       syndrome == 0
//   err        out  1       syndrome != 0
//   syndrome   out  32      final division remainder
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start; results from last check held
//   S_SHIFT | shifting one codeword bit per clock into the remainder
//   S_DONE  | final bit absorbed; publish result on the next edge
// ---------------------------------------------------------------------------
module crc32_check #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [31:0]      crc_i,
    input  logic [32:0]      polynom_i,
    output logic             busy,
    output logic             done,
    output logic             ok,
    output logic             err,
    output logic [31:0]      syndrome
);

    localparam int SR_W = WIDTH + 32;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SR_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SR_W-1:0]   sr;
    logic [31:0]       r;
    logic [31:0]       r_nxt;
    logic [31:0]       poly;
    logic [CNT_W-1:0]  cnt;
    logic              load;
    logic              shift_en;
    logic              finish;

    // The x^32 term is always present, so the top polynomial bit carries no
    // information for the division.
    logic poly_msb_unused;
    assign poly_msb_unused = polynom_i[32];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == LAST_CNT) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy     = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        case (state)
            S_IDLE: begin
                load = start;
            end
            S_SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
            end
            S_DONE: begin
                busy   = 1'b1;
                finish = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // One division step: bring in the next codeword bit, and reduce by the
    // polynomial when the bit falling out of the remainder (x^32) is set.
    always_comb begin
        r_nxt = {r[30:0], sr[SR_W-1]} ^ (r[31] ? poly : 32'd0);
    end

    // Datapath and registered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr       <= '0;
            r        <= '0;
            poly     <= '0;
            cnt      <= '0;
            done     <= 1'b0;
            ok       <= 1'b0;
            err      <= 1'b0;
            syndrome <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                sr   <= {data, crc_i};
                poly <= polynom_i[31:0];
                r    <= '0;
                cnt  <= '0;
                ok   <= 1'b0;
                err  <= 1'b0;
            end else if (shift_en) begin
                sr  <= {sr[SR_W-2:0], 1'b0};
                r   <= r_nxt;
                cnt <= cnt + 1'b1;
            end else if (finish) begin
                syndrome <= r;
                ok       <= (r == 32'd0);
                err      <= (r != 32'd0);
                done     <= 1'b1;
            end
        end
    end

endmodule
